// File: rtl/cla_pkg.sv
// Shared types and constants for the nibble-serial CLA scheduler.
// Nibble width and the sequencer state encoding.
`timescale 1ns/1ps
package cla_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } sched_state_t;

endpackage

// File: rtl/cla4_slice.sv
// 4-bit carry-lookahead adder slice, purely combinational.
// Ports: a, b, c_in -> sum, c_out.
`timescale 1ns/1ps
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = c_in;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0])
              | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign sum   = p ^ c[3:0];
  assign c_out = c[4];

endmodule

// File: rtl/cla_add_sched.sv
// Round-robin scheduler feeding two requesters into one 4-bit CLA slice.
// Ports: clk/rst, req0_*/req1_* request handshakes, res_* result handshake, busy.
`timescale 1ns/1ps
module cla_add_sched #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             res_id,
  output logic             busy
);
  import cla_pkg::*;

  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  sched_state_t     state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             last_id_q, last_id_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             id_q, id_d;

  logic       grant0, grant1;
  logic [3:0] a_nib, b_nib, s_sum;
  logic       s_cout;

  // On contention the requester not served last wins.
  assign grant0 = req0_valid & (~req1_valid | last_id_q);
  assign grant1 = req1_valid & (~req0_valid | ~last_id_q);

  assign req0_ready = ~rst & (state_q == S_IDLE) & grant0;
  assign req1_ready = ~rst & (state_q == S_IDLE) & grant1;

  assign res_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign res_sum   = sum_q;
  assign res_cout  = cout_q;
  assign res_id    = id_q;

  cla4_slice u_slice (
    .a     (a_nib),
    .b     (b_nib),
    .c_in  (carry_q),
    .sum   (s_sum),
    .c_out (s_cout)
  );

  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NIB; i++) begin
      if (cnt_q == CW'(i)) begin
        a_nib = a_q[i*NIBBLE_W +: NIBBLE_W];
        b_nib = b_q[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    last_id_d = last_id_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    id_d      = id_q;
    unique case (state_q)
      S_IDLE: begin
        if (req0_ready | req1_ready) begin
          a_d       = req1_ready ? req1_a : req0_a;
          b_d       = req1_ready ? req1_b : req0_b;
          carry_d   = req1_ready ? req1_cin : req0_cin;
          id_d      = req1_ready;
          last_id_d = req1_ready;
          cnt_d     = '0;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        for (int i = 0; i < NIB; i++) begin
          if (cnt_q == CW'(i)) begin
            sum_d[i*NIBBLE_W +: NIBBLE_W] = s_sum;
          end
        end
        carry_d = s_cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          cout_d  = s_cout;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      last_id_q <= 1'b1;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      id_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      carry_q   <= carry_d;
      last_id_q <= last_id_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
      id_q      <= id_d;
    end
  end

endmodule

// File: tb/tb_cla_add_sched.sv
// Self-checking bench for cla_add_sched (WIDTH=16).
// Scoreboard of {id,cout,sum} pushed on accept, popped on result.
`timescale 1ns/1ps
module tb_cla_add_sched;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready, req0_cin;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready, req1_cin;
  logic [W-1:0] req1_a, req1_b;
  logic         res_valid, res_ready, res_cout, res_id, busy;
  logic [W-1:0] res_sum;

  int n_chk  = 0;
  int n_fail = 0;

  logic [17:0] sb[$];
  int          acc_ids[$];
  int          res_cnt = 0;
  logic [15:0] last_sum;
  logic        last_cout, last_id;
  logic [17:0] e;

  always #5 clk = ~clk;

  cla_add_sched #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_sum    (res_sum),
    .res_cout   (res_cout),
    .res_id     (res_id),
    .busy       (busy)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] model(input logic id,
                                        input logic [15:0] a,
                                        input logic [15:0] b,
                                        input logic cin);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b} + {16'b0, cin};
    return {id, s};
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (req0_valid & req1_valid)
        chk("ready_excl", {31'b0, req0_ready & req1_ready}, 32'd0);
      if (req0_valid & req0_ready) begin
        sb.push_back(model(1'b0, req0_a, req0_b, req0_cin));
        acc_ids.push_back(0);
      end
      if (req1_valid & req1_ready) begin
        sb.push_back(model(1'b1, req1_a, req1_b, req1_cin));
        acc_ids.push_back(1);
      end
      if (res_valid & res_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("result", {14'b0, res_id, res_cout, res_sum}, {14'b0, e});
        end
        last_sum  = res_sum;
        last_cout = res_cout;
        last_id   = res_id;
        res_cnt++;
      end
    end
  end

  task automatic send(input logic id, input logic [15:0] a,
                      input logic [15:0] b, input logic cin);
    bit ok;
    @(posedge clk); #1;
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = cin;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = cin;
    end
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) ok = 1'b1;
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic wait_res(input int target);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(posedge clk);
      if (res_cnt >= target) ok = 1'b1;
    end
    if (!ok) chk("result_timeout", 32'd0, 32'd1);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
  endtask

  initial begin
    int n;
    bit ok;
    rst = 1'b1;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_cin = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_cin = 0;
    res_ready = 1'b1;

    @(posedge clk); #1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    @(negedge clk);
    chk("rst_ready0", {31'b0, req0_ready}, 32'd0);
    chk("rst_ready1", {31'b0, req1_ready}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_valid", {31'b0, res_valid}, 32'd0);
    chk("rst_sum", {16'b0, res_sum}, 32'd0);
    chk("rst_cout_id", {30'b0, res_cout, res_id}, 32'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b0;

    n = res_cnt;
    send(1'b0, 16'h1234, 16'h4321, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("latency_c%0d", k), {31'b0, res_valid},
          (k == 5) ? 32'd1 : 32'd0);
    end
    wait_res(n + 1);
    chk("t1_sum", {16'b0, last_sum}, 32'h5555);
    chk("t1_cout_id", {30'b0, last_cout, last_id}, 32'd0);

    n = res_cnt;
    send(1'b1, 16'hFFFF, 16'h0000, 1'b1);
    wait_res(n + 1);
    chk("t2_sum", {16'b0, last_sum}, 32'h0000);
    chk("t2_cout_id", {30'b0, last_cout, last_id}, 32'd3);

    n = res_cnt;
    send(1'b0, 16'h8000, 16'h8000, 1'b0);
    wait_res(n + 1);
    chk("t3_sum", {16'b0, last_sum}, 32'h0000);
    chk("t3_cout", {31'b0, last_cout}, 32'd1);

    for (int i = 0; i < 1000; i++) begin
      n = res_cnt;
      send(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
           1'($urandom_range(0, 1)));
      wait_res(n + 1);
    end

    do_reset();
    acc_ids.delete();
    n = res_cnt;
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_a = 16'h0F0F; req0_b = 16'h1111; req0_cin = 1'b0;
    req1_valid = 1'b1; req1_a = 16'hA000; req1_b = 16'h7001; req1_cin = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (acc_ids.size() >= 4) ok = 1'b1;
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("rr_count", {31'b0, ok}, 32'd1);
    wait_res(n + 4);
    if (acc_ids.size() >= 4) begin
      chk("rr_id0", 32'(acc_ids[0]), 32'd0);
      chk("rr_id1", 32'(acc_ids[1]), 32'd1);
      chk("rr_id2", 32'(acc_ids[2]), 32'd0);
      chk("rr_id3", 32'(acc_ids[3]), 32'd1);
    end

    res_ready = 1'b0;
    n = res_cnt;
    send(1'b0, 16'hABCD, 16'h1111, 1'b1);
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (res_valid) ok = 1'b1;
    end
    chk("bp_reach_done", {31'b0, ok}, 32'd1);
    @(posedge clk); #1;
    req1_valid = 1'b1; req1_a = 16'h0001; req1_b = 16'h0002; req1_cin = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_valid", {31'b0, res_valid}, 32'd1);
      chk("bp_sum", {16'b0, res_sum}, 32'hBCDF);
      chk("bp_cout_id", {30'b0, res_cout, res_id}, 32'd0);
      chk("bp_ready1", {31'b0, req1_ready}, 32'd0);
    end
    @(posedge clk); #1;
    req1_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_idle_busy", {31'b0, busy}, 32'd0);
    chk("bp_idle_valid", {31'b0, res_valid}, 32'd0);
    chk("bp_one_result", 32'(res_cnt - n), 32'd1);
    chk("bp_no_accept", 32'(sb.size()), 32'd0);

    n = res_cnt;
    send(1'b0, 16'h5A5A, 16'h1234, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_valid", {31'b0, res_valid}, 32'd0);
    for (int k = 0; k < 8; k++) @(negedge clk);
    chk("abort_no_result", 32'(res_cnt - n), 32'd0);
    send(1'b0, 16'h0001, 16'h0001, 1'b0);
    wait_res(n + 1);
    chk("post_sum", {16'b0, last_sum}, 32'h0002);
    chk("post_cout_id", {30'b0, last_cout, last_id}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
